// File: rtl/hs32_fetch_pkg.sv
// hs32_fetch_pkg: types shared by the HS32 instruction fetch unit.
//   hs32_instr     - one 32-bit instruction word as seen by decode
//   HS32_RESET_PC  - default first fetch address
//   hs32_fetch_ent - prefetch queue entry: instruction plus its address
package hs32_fetch_pkg;

    typedef logic [31:0] hs32_instr;

    localparam logic [31:0] HS32_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        hs32_instr   instr;
        logic [31:0] pc;
    } hs32_fetch_ent;

endpackage

// File: rtl/hs32_fetch_if.sv
// hs32_fetch_if: instruction bus between fetch (master) and memory (slave).
//   addr   - word-aligned read address, held stable while req && !gnt
//   req    - read request
//   gnt    - address accepted this cycle
//   rvalid - read data valid; responses are in order, >=1 cycle after grant
//   rdata  - read data
interface hs32_fetch_if;
    import hs32_fetch_pkg::*;

    logic [31:0] addr;
    logic        req;
    logic        gnt;
    logic        rvalid;
    hs32_instr   rdata;

    modport master (output addr, req, input gnt, rvalid, rdata);
    modport slave  (input addr, req, output gnt, rvalid, rdata);

endinterface

// File: rtl/hs32_fetch_fifo.sv
// hs32_fifo: small synchronous FIFO, no bypass from push to read port.
//   clk_i, reset_i - clock, synchronous active-high reset
//   flush_i        - synchronous empty (takes priority over push/pop)
//   push_i, data_i - write; accepted when not full or when popping this cycle
//   pop_i          - discard head; ignored when empty
//   data_o         - head entry (undefined content when empty)
//   count_o        - entries held; full_o / empty_o status
module hs32_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic          w_pop;
    logic          w_push;

    assign empty_o = (r_cnt == '0);
    assign full_o  = (r_cnt == (AW+1)'(DEPTH));
    assign w_pop   = pop_i && !empty_o;
    // A full queue may still take a word when its head leaves in the same cycle.
    assign w_push  = push_i && (!full_o || w_pop);
    assign data_o  = r_mem[r_rd];
    assign count_o = r_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= data_i;
    end

endmodule

// File: rtl/hs32_fetch.sv
// hs32_fetch: HS32 instruction fetch unit.
// Issues word reads, queues returned words in a DEPTH-entry prefetch queue and
// presents the head to decode. A branch flushes the queue, restarts fetch at
// the target and discards responses still in flight for the old stream.
//   clk_i, reset_i        - clock, synchronous active-high reset
//   ibus                  - instruction bus master port
//   br_valid_i/target_i   - redirect pulse and target (bits [1:0] ignored)
//   data_o, pc_o, valid_o - queue head instruction, its address, valid
//   stall_i               - decode stall: head is not consumed this cycle
module hs32_fetch
    import hs32_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = HS32_RESET_PC
) (
    input  logic                clk_i,
    input  logic                reset_i,
    hs32_fetch_if.master        ibus,
    input  logic                br_valid_i,
    input  logic [31:0]         br_target_i,
    output hs32_instr           data_o,
    output logic [31:0]         pc_o,
    output logic                valid_o,
    input  logic                stall_i
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_fpc;       // next fetch address
    logic [31:0]   r_fpc_head;  // address of the next word to be pushed
    logic [CW-1:0] r_outst;     // granted, not yet responded
    logic [CW-1:0] r_drop;      // responses still to discard after a branch

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_eff;
    logic [CW:0]   w_used;
    logic [CW-1:0] w_outst_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_gnt;
    logic          w_rsp;
    logic          w_push;
    logic [31:0]   w_tgt;
    hs32_fetch_ent w_head;
    hs32_fetch_ent w_push_ent;

    assign w_pop       = !w_empty && !stall_i;
    assign w_count_eff = w_count - CW'(w_pop);
    assign w_used      = {1'b0, w_count_eff} + {1'b0, r_outst};

    // Queued plus in-flight words never exceed DEPTH, so every response has a
    // slot waiting for it. The full check is implied by the sum; it just keeps
    // the common full-and-stalled case off the adder path.
    assign ibus.req  = !reset_i && (!w_full || w_pop) && (w_used < (CW+1)'(DEPTH));
    assign ibus.addr = r_fpc;

    assign w_gnt = ibus.req && ibus.gnt;
    // A response with nothing outstanding belongs to a transaction cut off by
    // reset and is ignored entirely.
    assign w_rsp = ibus.rvalid && (r_outst != '0);
    assign w_push = w_rsp && (r_drop == '0) && !br_valid_i;
    assign w_tgt  = {br_target_i[31:2], 2'b00};
    assign w_outst_nxt = r_outst + CW'(w_gnt) - CW'(w_rsp);

    assign w_push_ent = '{instr: ibus.rdata, pc: r_fpc_head};

    hs32_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(hs32_fetch_ent))
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (br_valid_i),
        .push_i  (w_push),
        .data_i  (w_push_ent),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_fpc      <= RESET_PC;
            r_fpc_head <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (br_valid_i) begin
                r_fpc      <= w_tgt;
                r_fpc_head <= w_tgt;
                // Everything in flight after this edge belongs to the old stream.
                r_drop     <= w_outst_nxt;
            end else begin
                if (w_gnt) r_fpc <= r_fpc + 32'd4;
                if (w_rsp) begin
                    if (r_drop != '0) r_drop     <= r_drop - CW'(1);
                    else              r_fpc_head <= r_fpc_head + 32'd4;
                end
            end
        end
    end

    // Head is zeroed while empty so decode never sees stale queue contents.
    assign valid_o = !w_empty;
    assign data_o  = w_empty ? '0 : w_head.instr;
    assign pc_o    = w_empty ? '0 : w_head.pc;

endmodule

// File: tb/tb_hs32_fetch.sv
module tb_hs32_fetch;
    import hs32_fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0100;

    typedef struct { logic [31:0] a; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] w; } exp_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        br_valid_i = 1'b0;
    logic [31:0] br_target_i = '0;
    logic        stall_i = 1'b0;
    hs32_instr   data_o;
    logic [31:0] pc_o;
    logic        valid_o;

    hs32_fetch_if bus ();

    hs32_fetch #(.DEPTH(2), .RESET_PC(RPC)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .ibus        (bus),
        .br_valid_i  (br_valid_i),
        .br_target_i (br_target_i),
        .data_o      (data_o),
        .pc_o        (pc_o),
        .valid_o     (valid_o),
        .stall_i     (stall_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int cyc    = 0;

    // Bus and stream knobs
    int  gnt_pct = 100, rsp_pct = 100, lat_max = 1, stall_pct = 0, br_pct = 0;
    int  f_stall = 0;     // -1 random, 0/1 forced
    bit  f_rst = 1'b1, f_br = 1'b0, f_stale = 1'b0;
    logic [31:0] f_tgt = '0;
    int  stale_n = 0;

    pend_t pend[$];       // bus: granted reads awaiting response
    exp_t  exp_q[$];      // architectural instruction stream still to be consumed
    logic [31:0] nxt = RPC;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // One clock: drive inputs at +1, record bus/stream effects at +2.
    task automatic step();
        int lat;
        @(posedge clk); #1; cyc++;
        reset_i   = f_rst;
        bus.gnt   = ($urandom_range(99) < gnt_pct);
        bus.rvalid = 1'b0;
        bus.rdata  = $urandom;
        if (f_stale && stale_n > 0) begin
            bus.rvalid = 1'b1;
            stale_n--;
        end else if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
            bus.rvalid = 1'b1;
            bus.rdata  = memw(pend[0].a);
            void'(pend.pop_front());
        end
        stall_i     = (f_stall >= 0) ? (f_stall != 0) : ($urandom_range(99) < stall_pct);
        br_valid_i  = !f_rst && (f_br || ($urandom_range(99) < br_pct));
        br_target_i = f_br ? f_tgt : $urandom;
        f_br = 1'b0;
        #1;
        if (reset_i) begin
            stale_n += pend.size();
            pend.delete();
            exp_q.delete();
            nxt = RPC;
        end else begin
            if (bus.req && bus.gnt) begin
                lat = $urandom_range(lat_max, 1);
                pend.push_back('{bus.addr, cyc + lat});
            end
            if (br_valid_i) begin
                exp_q.delete();
                nxt = {br_target_i[31:2], 2'b00};
            end
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back('{nxt, memw(nxt)});
            nxt += 32'd4;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (valid_o !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(nm, {31'd0, valid_o}, 32'd1);
    endtask

    // Monitor: consumes the expected stream whenever decode takes the head.
    initial begin
        bit pv = 0, ps = 0, pb = 0, prst = 0;
        logic [31:0] pd = '0, pp = '0;
        exp_t e;
        forever begin
            @(posedge clk); #3;
            if (reset_i) begin
                chk("reset_req", {31'd0, bus.req}, 32'd0);
                if (prst) begin
                    chk("reset_valid", {31'd0, valid_o}, 32'd0);
                    chk("reset_data", data_o, 32'd0);
                    chk("reset_pc", pc_o, 32'd0);
                    chk("reset_addr", bus.addr, RPC);
                end
            end else begin
                if (pb) chk("valid_after_branch", {31'd0, valid_o}, 32'd0);
                if (pv && ps && !pb && !prst) begin
                    chk("stall_valid", {31'd0, valid_o}, 32'd1);
                    chk("stall_data", data_o, pd);
                    chk("stall_pc", pc_o, pp);
                end
                if (bus.req) chk("addr_align", {30'd0, bus.addr[1:0]}, 32'd0);
                if (valid_o && !stall_i && !br_valid_i) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL stream got pc %h with no expected entry", pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("stream_pc", pc_o, e.pc);
                        chk("stream_data", data_o, e.w);
                        pops++;
                    end
                end
            end
            pv = valid_o; ps = stall_i; pb = br_valid_i; prst = reset_i;
            pd = data_o; pp = pc_o;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal;
    end

    initial begin
        int nv, p0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;

        // Reset and streaming
        steps(3);
        f_rst = 1'b0;
        step();
        chk("first_req", {31'd0, bus.req}, 32'd1);
        chk("first_addr", bus.addr, RPC);
        chk("first_valid_r0", {31'd0, valid_o}, 32'd0);
        step();
        chk("first_valid_r1", {31'd0, valid_o}, 32'd0);
        step();
        chk("stream0_valid", {31'd0, valid_o}, 32'd1);
        chk("stream0_pc", pc_o, 32'h100);
        step();
        chk("stream1_pc", pc_o, 32'h104);
        step();
        chk("stream2_pc", pc_o, 32'h108);
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (valid_o) nv++;
        end
        chk("throughput", nv, 32'd10);

        // Stall backpressure
        f_stall = 1;
        steps(5);
        chk("stall_req_low", {31'd0, bus.req}, 32'd0);
        chk("stall_head_valid", {31'd0, valid_o}, 32'd1);
        f_stall = 0;
        steps(6);

        // Branch with two outstanding, stale responses discarded
        rsp_pct = 0;
        steps(6);
        f_br = 1'b1; f_tgt = 32'h0000_2003;
        step();
        rsp_pct = 100;
        wait_valid("br2_wait");
        chk("br2_pc", pc_o, 32'h2000);
        chk("br2_data", data_o, memw(32'h2000));
        steps(6);

        // Branch in the same cycle as a grant and a response
        f_br = 1'b1; f_tgt = 32'h0000_3000;
        step();
        chk("simul_req", {31'd0, bus.req}, 32'd1);
        step();
        chk("simul_tgt_req", {31'd0, bus.req}, 32'd1);
        chk("simul_tgt_addr", bus.addr, 32'h3000);
        wait_valid("simul_wait");
        chk("simul_pc", pc_o, 32'h3000);
        chk("simul_data", data_o, memw(32'h3000));
        steps(4);

        // Address wrap
        f_br = 1'b1; f_tgt = 32'hFFFF_FFFE;
        step();
        step();
        chk("wrap_addr0", bus.addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr1", bus.addr, 32'h0000_0000);
        steps(8);

        // Randomised traffic
        p0 = pops;
        gnt_pct = 60; rsp_pct = 70; lat_max = 3; stall_pct = 30; br_pct = 5; f_stall = -1;
        steps(3000);
        chk("random_progress", {31'd0, pops > p0 + 200}, 32'd1);

        // Reset with two outstanding, then two stray responses
        gnt_pct = 100; rsp_pct = 100; lat_max = 1; stall_pct = 0; br_pct = 0; f_stall = 0;
        steps(6);
        rsp_pct = 0;
        steps(8);
        stale_n = 0;
        f_rst = 1'b1;
        step();
        f_rst = 1'b0; gnt_pct = 0; f_stale = 1'b1;
        step();
        chk("rst_mid_valid0", {31'd0, valid_o}, 32'd0);
        chk("rst_mid_req", {31'd0, bus.req}, 32'd1);
        chk("rst_mid_addr", bus.addr, RPC);
        step();
        chk("rst_mid_valid1", {31'd0, valid_o}, 32'd0);
        step();
        chk("rst_mid_valid2", {31'd0, valid_o}, 32'd0);
        f_stale = 1'b0; gnt_pct = 100; rsp_pct = 100;
        wait_valid("rst_mid_wait");
        chk("rst_mid_pc", pc_o, RPC);
        chk("rst_mid_data", data_o, memw(RPC));
        steps(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
